sample_feeder: RTL
==================

# sample_feeder

Upstream data source for the neuron training module. Holds a small training set of signed (X1, X2, t) samples written in through a load port. On command it issues the sample count and a start pulse to the neuron. It then streams samples in order, one per cycle while the neuron signals readiness, wrapping epoch after epoch until the neuron reports done.

## Interface
Parameters:
- DEPTH, 16: sample storage capacity (power of two, 2..256)
- XW, 7: width of signed X1/X2 samples
- TW, 2: width of signed target t

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  reset; asynchronous, active-high
- wrEn  in  1  write one sample into the next free slot
- wrX1, wrX2  in  XW  signed sample inputs for the load port
- wrT  in  TW  signed target input for the load port
- clear  in  1  empty the buffer (count to 0)
- go  in  1  begin a training run
- readyToGetData  in  1  neuron requests the next sample
- done  in  1  neuron training finished
- X1Bus, X2Bus  out  XW  registered sample to neuron
- tBus  out  TW  registered target to neuron
- nBus  out  32  number of stored samples, zero-extended
- start  out  1  start pulse to neuron
- epoch  out  16  completed passes over the set, saturating
- busy  out  1  high in START and RUN
- full  out  1  count == DEPTH

## Operation
- Storage: arrays of DEPTH entries, a write pointer equal to count, and a read index idx.
- States are IDLE, START, RUN and FINISHED.
- IDLE:
  - wrEn with count < DEPTH stores the sample at slot count, and count increments.
  - wrEn while full is ignored; contents are unchanged.
  - clear sets count to 0. If clear and wrEn are high together, clear wins.
  - go with count > 0 goes to START, with idx=0 and epoch=0.
  - go with count == 0 is ignored.
- START: lasts exactly 2 cycles with start=1, then moves to RUN. nBus is valid from the first START cycle onward.
- RUN:
  - On each edge where readyToGetData=1, load sample[idx] into X1Bus/X2Bus/tBus.
  - idx then advances. After idx == count-1 it wraps to 0, and epoch increments (saturating at 16'hFFFF).
  - With readyToGetData=0, the buses and idx hold.
- done=1 in START or RUN goes to FINISHED on the next edge. done has priority over a same-cycle readyToGetData, so no further sample is issued.
- FINISHED:
  - Buses, epoch and idx hold.
  - go with count > 0 restarts (to START, idx=0, epoch=0).
  - clear returns to IDLE with count=0.
- In START, RUN and FINISHED, wrEn is ignored. clear is ignored in START and RUN.
- All arithmetic is unsigned except the sample data, which passes through bit-exact.

## Timing
- Reset values: X1Bus=0, X2Bus=0, tBus=0, nBus=0, start=0, epoch=0, busy=0, full=0, state=IDLE, count=0, idx=0. Reset takes effect immediately, including mid-RUN.
- A load write is visible in nBus and full one cycle after the wrEn edge.
- Edge 0 is the edge where go is sampled in IDLE:
  - start is high after edges 0 and 1, and low after edge 2.
  - RUN begins after edge 2. The first readyToGetData can be sampled at edge 3.
- Sample latency: readyToGetData sampled high at edge k puts its sample on the buses after edge k. The sample is therefore stable for the neuron at edge k+1.
- Back-to-back ready cycles give one new sample per cycle with no bubbles.
- epoch updates on the same edge that issues sample count-1.
- busy is registered and follows the state in the same cycle.

## Test plan
- Load 4 samples (3,-2,1), (-5,7,-1), (0,1,1), (-64,63,-1), then pulse go. Required: nBus=4, start high for exactly 2 cycles, busy=1.
- Hold readyToGetData high for 9 cycles. Required: the buses cycle through samples 0,1,2,3,0,1,2,3,0; epoch reads 1 after the 4th sample and 2 after the 8th.
- Toggle readyToGetData 1,0,0,1. Required: the buses hold sample 0 through both idle cycles, then sample 1 appears; idx does not advance while ready is low.
- Load 17 writes with DEPTH=16. Required: full=1 after 16 writes, the 17th is dropped, and nBus=16. Then go with count=0 after clear: required no start, state stays IDLE.
- Mid-RUN, assert done and readyToGetData together. Required: FINISHED, buses unchanged, epoch frozen. Then go: required epoch=0 and a fresh 2-cycle start.
- Assert rst asynchronously mid-RUN, between edges. Required: all outputs read 0 immediately, count=0, state IDLE. After release, go is ignored until a sample is loaded.

Source files
------------

// File: rtl/sample_feeder.sv
// sample_feeder: stores a small signed training set through a load port and
// streams it to the neuron one sample per ready cycle, epoch after epoch,
// until the neuron reports done.
module sample_feeder #(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned XW    = 7,
   parameter int unsigned TW    = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          wrEn,
   input  logic [XW-1:0] wrX1,
   input  logic [XW-1:0] wrX2,
   input  logic [TW-1:0] wrT,
   input  logic          clear,
   input  logic          go,
   input  logic          readyToGetData,
   input  logic          done,
   output logic [XW-1:0] X1Bus,
   output logic [XW-1:0] X2Bus,
   output logic [TW-1:0] tBus,
   output logic [31:0]   nBus,
   output logic          start,
   output logic [15:0]   epoch,
   output logic          busy,
   output logic          full
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = AW + 1;

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_START    = 2'd1,
      S_RUN      = 2'd2,
      S_FINISHED = 2'd3
   } state_t;

   state_t        state;
   state_t        state_nxt;

   logic [XW-1:0] mem_x1 [DEPTH];
   logic [XW-1:0] mem_x2 [DEPTH];
   logic [TW-1:0] mem_t  [DEPTH];

   logic [CW-1:0] count;
   logic [CW-1:0] count_nxt;
   logic [AW-1:0] idx;
   logic [AW-1:0] idx_nxt;
   logic          start_second;
   logic          start_second_nxt;
   logic [15:0]   epoch_nxt;
   logic [XW-1:0] x1_nxt;
   logic [XW-1:0] x2_nxt;
   logic [TW-1:0] t_nxt;
   logic          start_nxt;
   logic          busy_nxt;
   logic          full_nxt;
   logic          wr_ok;
   logic          go_ok;
   logic          issue;
   logic          can_cmd;

   // Commands (load, clear, go) are only honoured while not streaming.
   assign can_cmd = (state == S_IDLE) || (state == S_FINISHED);
   assign wr_ok   = (state == S_IDLE) && wrEn && !clear && (count != CW'(DEPTH));
   assign go_ok   = can_cmd && go && !clear && (count != '0);
   assign issue   = (state == S_RUN) && readyToGetData && !done;

   // nBus is the count register itself, zero-extended.
   assign nBus = 32'(count);

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic; done beats readyToGetData, clear beats go.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (go_ok) begin
               state_nxt = S_START;
            end
         end
         S_START: begin
            if (done) begin
               state_nxt = S_FINISHED;
            end else if (start_second) begin
               state_nxt = S_RUN;
            end
         end
         S_RUN: begin
            if (done) begin
               state_nxt = S_FINISHED;
            end
         end
         S_FINISHED: begin
            if (clear) begin
               state_nxt = S_IDLE;
            end else if (go_ok) begin
               state_nxt = S_START;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Next values for the registered outputs and datapath.
   always_comb begin
      count_nxt        = count;
      idx_nxt          = idx;
      epoch_nxt        = epoch;
      x1_nxt           = X1Bus;
      x2_nxt           = X2Bus;
      t_nxt            = tBus;
      start_second_nxt = (state == S_START);

      if (can_cmd && clear) begin
         count_nxt = '0;
      end else if (wr_ok) begin
         count_nxt = count + CW'(1);
      end

      if (go_ok) begin
         idx_nxt   = '0;
         epoch_nxt = '0;
      end

      if (issue) begin
         x1_nxt = mem_x1[idx];
         x2_nxt = mem_x2[idx];
         t_nxt  = mem_t[idx];
         if (idx == AW'(count - CW'(1))) begin
            idx_nxt = '0;
            if (epoch != 16'hFFFF) begin
               epoch_nxt = epoch + 16'd1;
            end
         end else begin
            idx_nxt = idx + AW'(1);
         end
      end

      start_nxt = (state_nxt == S_START);
      busy_nxt  = (state_nxt == S_START) || (state_nxt == S_RUN);
      full_nxt  = (count_nxt == CW'(DEPTH));
   end

   // Registered outputs, counters and sequencing flags.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count        <= '0;
         idx          <= '0;
         epoch        <= '0;
         X1Bus        <= '0;
         X2Bus        <= '0;
         tBus         <= '0;
         start        <= 1'b0;
         busy         <= 1'b0;
         full         <= 1'b0;
         start_second <= 1'b0;
      end else begin
         count        <= count_nxt;
         idx          <= idx_nxt;
         epoch        <= epoch_nxt;
         X1Bus        <= x1_nxt;
         X2Bus        <= x2_nxt;
         tBus         <= t_nxt;
         start        <= start_nxt;
         busy         <= busy_nxt;
         full         <= full_nxt;
         start_second <= start_second_nxt;
      end
   end

   // Sample storage; the write slot is the current count.
   always_ff @(posedge clk) begin
      if (wr_ok) begin
         mem_x1[count[AW-1:0]] <= wrX1;
         mem_x2[count[AW-1:0]] <= wrX2;
         mem_t[count[AW-1:0]]  <= wrT;
      end
   end

endmodule
